// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D block-RAM arbiter: response-slot states and port indices.
package mem_arb_pkg;
  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_INFLIGHT, SLOT_HELD} slot_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One-entry response buffer: forwards RAM data the cycle after a grant and
// captures it if the consumer stalls, so the RAM is never re-read.
module mem_arb_rsp_slot
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        rsp_ready,
  input  logic [31:0] ram_dout,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        free
);
  slot_e       state, state_n;
  logic [31:0] hold_data;
  logic        consume;

  assign rsp_valid = (state != SLOT_EMPTY);
  assign consume   = rsp_valid & rsp_ready;
  // Emptying this cycle frees the slot for a back-to-back request.
  assign free      = ~rsp_valid | rsp_ready;
  assign rsp_data  = (state == SLOT_HELD) ? hold_data : ram_dout;

  always_comb begin
    state_n = state;
    if (hs)                          state_n = SLOT_INFLIGHT;
    else if (consume)                state_n = SLOT_EMPTY;
    else if (state == SLOT_INFLIGHT) state_n = SLOT_HELD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SLOT_EMPTY;
      hold_data <= '0;
    end else begin
      state <= state_n;
      if (state == SLOT_INFLIGHT && !consume && !hs)
        hold_data <= ram_dout;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one read-first, 1-cycle-latency block RAM
// between an instruction-fetch port (I) and a load/store port (D).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_req_valid,
  output logic           i_req_ready,
  input  logic [MEM-1:0] i_req_addr,
  output logic           i_rsp_valid,
  output logic [31:0]    i_rsp_data,
  input  logic           i_rsp_ready,
  input  logic           d_req_valid,
  output logic           d_req_ready,
  input  logic           d_req_we,
  input  logic [MEM-1:0] d_req_addr,
  input  logic [31:0]    d_req_wdata,
  output logic           d_rsp_valid,
  output logic [31:0]    d_rsp_data,
  input  logic           d_rsp_ready,
  output logic           ram_we,
  output logic [MEM-1:0] ram_addr,
  output logic [31:0]    ram_din,
  input  logic [31:0]    ram_dout
);
  logic           i_free, d_free, i_elig, d_elig, i_grant, d_grant, i_hs, d_hs;
  logic           last_grant;
  logic [MEM-1:0] addr_q;
  logic [31:0]    din_q;

  assign i_elig  = i_req_valid & i_free;
  assign d_elig  = d_req_valid & d_free;
  assign i_grant = i_elig & (~d_elig | (last_grant == PORT_D));
  assign d_grant = d_elig & (~i_elig | (last_grant == PORT_I));

  assign i_req_ready = i_grant & ~rst;
  assign d_req_ready = d_grant & ~rst;
  assign i_hs        = i_req_ready & i_req_valid;
  assign d_hs        = d_req_ready & d_req_valid;

  // Address/data hold their last driven value when idle to avoid RAM-pin toggling.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    if (i_hs) begin
      ram_addr = i_req_addr;
    end else if (d_hs) begin
      ram_addr = d_req_addr;
      ram_we   = d_req_we;
      ram_din  = d_req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_D;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      addr_q <= ram_addr;
      din_q  <= ram_din;
      if (i_hs)      last_grant <= PORT_I;
      else if (d_hs) last_grant <= PORT_D;
    end
  end

  mem_arb_rsp_slot u_i_slot (
    .clk       (clk),
    .rst       (rst),
    .hs        (i_hs),
    .rsp_ready (i_rsp_ready),
    .ram_dout  (ram_dout),
    .rsp_valid (i_rsp_valid),
    .rsp_data  (i_rsp_data),
    .free      (i_free)
  );

  mem_arb_rsp_slot u_d_slot (
    .clk       (clk),
    .rst       (rst),
    .hs        (d_hs),
    .rsp_ready (d_rsp_ready),
    .ram_dout  (ram_dout),
    .rsp_valid (d_rsp_valid),
    .rsp_data  (d_rsp_data),
    .free      (d_free)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural RAM, a reference memory and
// per-port expected-response queues checked by a negedge monitor.
module tb_mem_arbiter;
  localparam int MEM   = 10;
  localparam int WORDS = 1 << MEM;

  logic           clk = 0, rst = 1, load = 1;
  logic           i_req_valid = 0, i_rsp_ready = 0;
  logic [MEM-1:0] i_req_addr = '0;
  logic           d_req_valid = 0, d_req_we = 0, d_rsp_ready = 0;
  logic [MEM-1:0] d_req_addr = '0;
  logic [31:0]    d_req_wdata = '0;
  logic           i_req_ready, i_rsp_valid, d_req_ready, d_rsp_valid, ram_we;
  logic [31:0]    i_rsp_data, d_rsp_data, ram_din, ram_dout;
  logic [MEM-1:0] ram_addr;

  logic [31:0] init_mem [WORDS];
  logic [31:0] mem      [WORDS];
  logic [31:0] ref_mem  [WORDS];
  logic [31:0] iq[$], dq[$];
  int checks = 0, errors = 0;
  int i_grants = 0, d_grants = 0;
  logic        ref_last = 1'b1;
  logic        i_prev_stall = 0, d_prev_stall = 0;
  logic [31:0] i_prev_data = '0, d_prev_data = '0;

  mem_arbiter #(.MEM(MEM)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_ready(i_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_ready(d_rsp_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM with registered output.
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= init_mem[k];
    end else begin
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: everything observed here resolves at the following posedge.
  always @(negedge clk) begin
    logic ei, ed, exp_i, exp_d;
    if (load) for (int k = 0; k < WORDS; k++) ref_mem[k] = init_mem[k];
    if (rst) begin
      iq.delete(); dq.delete();
      ref_last = 1'b1;
      i_prev_stall = 0; d_prev_stall = 0;
    end else begin
      ei = i_req_valid & (!i_rsp_valid | i_rsp_ready);
      ed = d_req_valid & (!d_rsp_valid | d_rsp_ready);
      exp_i = ei & (!ed | ref_last);
      exp_d = ed & (!ei | !ref_last);
      chk("i_req_ready", {31'b0, i_req_ready}, {31'b0, exp_i});
      chk("d_req_ready", {31'b0, d_req_ready}, {31'b0, exp_d});
      chk("i_rsp_valid", {31'b0, i_rsp_valid}, {31'b0, iq.size() > 0});
      chk("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, dq.size() > 0});
      if (i_prev_stall) chk("i_hold_data", i_rsp_data, i_prev_data);
      if (d_prev_stall) chk("d_hold_data", d_rsp_data, d_prev_data);
      if (i_rsp_valid && iq.size() > 0) begin
        chk("i_rsp_data", i_rsp_data, iq[0]);
        if (i_rsp_ready) void'(iq.pop_front());
      end
      if (d_rsp_valid && dq.size() > 0) begin
        chk("d_rsp_data", d_rsp_data, dq[0]);
        if (d_rsp_ready) void'(dq.pop_front());
      end
      i_prev_stall = i_rsp_valid & !i_rsp_ready; i_prev_data = i_rsp_data;
      d_prev_stall = d_rsp_valid & !d_rsp_ready; d_prev_data = d_rsp_data;
      chk("ram_we", {31'b0, ram_we},
          {31'b0, d_req_valid & d_req_ready & d_req_we});
      if (i_req_valid && i_req_ready) begin
        iq.push_back(ref_mem[i_req_addr]);
        ref_last = 1'b0; i_grants++;
      end
      if (d_req_valid && d_req_ready) begin
        dq.push_back(ref_mem[d_req_addr]);
        if (d_req_we) ref_mem[d_req_addr] = d_req_wdata;
        ref_last = 1'b1; d_grants++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    i_req_valid = 0; d_req_valid = 0; d_req_we = 0;
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) init_mem[k] = $urandom;
    init_mem[5]     = 32'h0000_00AA;
    init_mem[16]    = 32'hDEAD_BEEF;
    tick(2);
    chk("rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
    chk("rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
    chk("rst_i_req_ready", {31'b0, i_req_ready}, 32'd0);
    chk("rst_d_req_ready", {31'b0, d_req_ready}, 32'd0);
    chk("rst_ram_we",      {31'b0, ram_we},      32'd0);
    load = 0; rst = 0;
    tick(1);

    // Single I stream on address 5.
    i_rsp_ready = 1; d_rsp_ready = 1;
    i_req_valid = 1; i_req_addr = 10'h005;
    tick(4);
    idle(); tick(2);

    // Both ports streaming: grants must alternate.
    i_grants = 0; d_grants = 0;
    i_req_valid = 1; d_req_valid = 1; d_req_we = 0;
    for (int c = 0; c < 8; c++) begin
      i_req_addr = MEM'(c); d_req_addr = MEM'(c + 100); tick(1);
    end
    idle(); tick(2);
    chk("alt_i_grants", i_grants, 32'd4);
    chk("alt_d_grants", d_grants, 32'd4);

    // Store read-first, then load back.
    d_req_valid = 1; d_req_we = 1; d_req_addr = 10'h010; d_req_wdata = 32'h1234_5678;
    tick(1);
    d_req_we = 0; tick(1);
    idle(); tick(2);

    // Backpressure on I while D streams.
    i_req_valid = 1; i_req_addr = 10'h005; tick(1);
    i_rsp_ready = 0; i_req_addr = 10'h006;
    d_req_valid = 1; d_req_addr = 10'h020;
    tick(3);
    i_rsp_ready = 1; tick(3);
    idle(); tick(2);

    // Reset with both slots held.
    i_rsp_ready = 0; d_rsp_ready = 0;
    i_req_valid = 1; d_req_valid = 1; tick(3);
    rst = 1; #1;
    chk("mid_rst_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
    chk("mid_rst_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
    chk("mid_rst_i_req_ready", {31'b0, i_req_ready}, 32'd0);
    chk("mid_rst_d_req_ready", {31'b0, d_req_ready}, 32'd0);
    tick(1); rst = 0; i_rsp_ready = 1; d_rsp_ready = 1; #1;
    chk("post_rst_first_i", {31'b0, i_req_ready}, 32'd1);
    chk("post_rst_first_d", {31'b0, d_req_ready}, 32'd0);
    tick(1);

    // Random traffic over a small address window to provoke RAW hazards.
    for (int c = 0; c < 3000; c++) begin
      i_req_valid = ($urandom_range(0, 3) != 0);
      i_req_addr  = MEM'($urandom_range(0, 31));
      d_req_valid = ($urandom_range(0, 3) != 0);
      d_req_we    = $urandom_range(0, 1);
      d_req_addr  = MEM'($urandom_range(0, 31));
      d_req_wdata = $urandom;
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    idle(); i_rsp_ready = 1; d_rsp_ready = 1; tick(3);
    chk("drain_i", iq.size(), 32'd0);
    chk("drain_d", dq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, read-first, 1-cycle-latency 32-bit block RAM between the core's instruction-fetch port (I, read-only) and load/store port (D, read/write). Each port has a valid/ready request channel and a valid/ready response channel. Conflicts are resolved round-robin. Responses are buffered per port, so either port can sustain one access per cycle when the other is idle.

## Interface
- MEM, 10, RAM address width in words; the RAM holds 2^MEM words
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch request accepted this cycle when high with i_req_valid
- i_req_addr  in  MEM  fetch word address
- i_rsp_valid  out  1  fetch data valid
- i_rsp_data  out  32  fetch data
- i_rsp_ready  in  1  fetch consumer takes the response
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store request accepted
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  MEM  word address
- d_req_wdata  in  32  store data
- d_rsp_valid  out  1  load/store response valid (stores also respond)
- d_rsp_data  out  32  load data; for a store, the old word (read-first)
- d_rsp_ready  in  1  consumer takes the response
- ram_we  out  1  RAM write enable
- ram_addr  out  MEM  RAM address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM registered read data, valid the cycle after the address

## Operation
- Each port has a response slot with states EMPTY, INFLIGHT and HELD.
- Port X is eligible when X_req_valid is high and either its slot is EMPTY, or the slot is non-empty and X_rsp_valid & X_rsp_ready are high this cycle.
- Grant, combinational:
  - only one port eligible: that port is granted;
  - both eligible: the port not in last_grant is granted.
- A request handshake occurs when X_req_ready & X_req_valid. On a handshake last_grant <= X.
- X_req_ready is high iff port X is granted.
- RAM drive:
  - granted I: ram_addr = i_req_addr, ram_we = 0;
  - granted D: ram_addr = d_req_addr, ram_we = d_req_we, ram_din = d_req_wdata;
  - no grant: ram_we = 0, and ram_addr/ram_din hold their last values (don't-care).
- Slot transitions, per port, on posedge:
  - handshake: slot -> INFLIGHT;
  - INFLIGHT, no consume: -> HELD, and hold_data <= ram_dout;
  - INFLIGHT or HELD, consume, no new handshake: -> EMPTY;
  - HELD, no consume: stays HELD.
- Response outputs:
  - X_rsp_valid = (slot != EMPTY);
  - X_rsp_data = ram_dout when INFLIGHT, hold_data when HELD.
- Consume = X_rsp_valid & X_rsp_ready.
- Simultaneous consume and new handshake on the same port is legal. The slot goes to INFLIGHT, and throughput is one access per cycle.
- A write and a read to the same address in consecutive cycles: the read returns the new data, via the RAM.

## Timing
- Reset values: both slots EMPTY, last_grant = D (so I wins the first conflict), hold_data = 0.
- Reset outputs: every *_rsp_valid = 0, every *_req_ready = 0, ram_we = 0.
- While rst is high both req_ready outputs are forced to 0.
- Latency: request handshake in cycle N -> X_rsp_valid high in cycle N+1 with data.
- A response is held stable until consumed; a response is never dropped or duplicated.
- Aggregate throughput: one RAM access per cycle. With both ports streaming and consuming every cycle, grants alternate I, D, I, D.
- A port whose response is stalled (rsp_ready low) gets no grant. The other port then receives every cycle.
- Reset mid-operation: in-flight and held responses are discarded. A write already presented to the RAM in the reset cycle is not guaranteed.

## Structure
- Package mem_arb_pkg:
  - slot state enum: SLOT_EMPTY, SLOT_INFLIGHT, SLOT_HELD;
  - port index constants: PORT_I = 0, PORT_D = 1.
- Sub-module mem_arb_rsp_slot, instantiated twice. It holds the slot FSM, hold_data and the rsp mux, and outputs "free", meaning the slot can accept a handshake this cycle.
- Top level: eligibility, round-robin grant, last_grant register, RAM drive muxing.
- The RAM itself is instantiated outside this block.

## Test plan
- Reset and idle: assert rst mid-stream with both slots busy -> all rsp_valid and req_ready drop immediately; after release, the first conflict grants I.
- Single I read: i_req addr 0x005, RAM word 0x0000_00AA, i_rsp_ready = 1 -> i_rsp_valid one cycle later with 0x0000_00AA; i_req_ready = 1 on every cycle of a continuous stream.
- Conflict alternation: both ports request every cycle with rsp_ready = 1 -> grants I, D, I, D…, each port at 50 % bandwidth, responses in order.
- Store read-first: D writes 0x1234_5678 to 0x010 (old word 0xDEAD_BEEF) -> d_rsp_data = 0xDEAD_BEEF; a following D load of 0x010 -> 0x1234_5678.
- Backpressure: i_rsp_ready = 0 for 3 cycles after an I response -> i_rsp_data stable (HELD), i_req_ready = 0, D granted every cycle; raise i_rsp_ready -> consumed, and a new I handshake happens in the same cycle.
- Random: both ports issue random requests with random rsp_ready, checked against a reference memory model -> no lost or duplicated responses, and no port starved for more than 1 cycle while its slot is free.
